// File: rtl/wload_seq.sv
// Weight/bias frame loader: streams NWORDS words into a shadow bank, checks an
// XOR checksum word, then commits the whole frame to wbus on a single edge.
module wload_seq #(
  parameter int NWORDS = 17,
  parameter int AW     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic [32*NWORDS-1:0]   wbus,
  output logic                   busy,
  output logic                   loaded,
  output logic                   err,
  output logic [AW-1:0]          idx
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t                   r_state, w_state_nxt;
  logic [AW-1:0]            r_idx;
  logic [31:0]              r_csum;
  logic [NWORDS-1:0][31:0]  r_shadow;
  logic [NWORDS-1:0][31:0]  r_wbus;
  logic                     r_loaded, r_err;
  logic                     w_start, w_wr, w_last, w_commit, w_fail;

  assign w_last = (r_idx == AW'(NWORDS-1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_start     = 1'b1;
        w_state_nxt = LOAD;
      end
      LOAD: if (in_valid) begin
        w_wr = 1'b1;
        if (w_last) w_state_nxt = CHECK;
      end
      CHECK: if (in_valid) begin
        if (in_data == r_csum) w_commit = 1'b1;
        else                   w_fail   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_csum   <= '0;
      r_wbus   <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_start) begin
        r_idx    <= '0;
        r_csum   <= '0;
        r_loaded <= 1'b0;
        r_err    <= 1'b0;
      end
      if (w_wr) begin
        r_csum <= r_csum ^ in_data;
        // idx parks on the last word so CHECK still reports NWORDS-1
        if (!w_last) r_idx <= r_idx + AW'(1);
      end
      if (w_commit) begin
        r_wbus   <= r_shadow;
        r_loaded <= 1'b1;
      end
      if (w_fail) r_err <= 1'b1;
    end
  end

  // Shadow bank is never reset: every slot is rewritten before any commit.
  always_ff @(posedge clk) begin
    if (w_wr) r_shadow[r_idx] <= in_data;
  end

  assign in_ready = (r_state != IDLE);
  assign busy     = (r_state != IDLE);
  assign wbus     = r_wbus;
  assign loaded   = r_loaded;
  assign err      = r_err;
  assign idx      = r_idx;

endmodule

// File: tb/tb_wload_seq.sv
// Bench for wload_seq: constant vector table, directed frame scenarios and
// random traffic, all checked against a queue-based frame model.
module tb_wload_seq;
  localparam int N  = 17;
  localparam int AW = 5;
  localparam int WB = 32*N;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [31:0]       in_data;
  logic              in_ready, busy, loaded, err;
  logic [WB-1:0]     wbus;
  logic [AW-1:0]     idx;

  int checks = 0;
  int failures = 0;

  wload_seq #(.NWORDS(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wbus(wbus), .busy(busy),
    .loaded(loaded), .err(err), .idx(idx)
  );

  always #5 clk = ~clk;

  // Model: frame = queue of received words; the word after N words is the checksum.
  bit               m_busy = 0;
  logic [31:0]      m_q[$];
  logic [N-1:0][31:0] m_wbus = '0;
  bit               m_loaded = 0, m_err = 0;
  int               m_idx = 0;

  function automatic logic [31:0] qxor();
    logic [31:0] x = '0;
    foreach (m_q[i]) x ^= m_q[i];
    return x;
  endfunction

  task automatic model(input logic s, input logic v, input logic [31:0] d, input logic r);
    if (r) begin
      m_busy = 0; m_q.delete(); m_wbus = '0; m_loaded = 0; m_err = 0; m_idx = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_q.delete(); m_loaded = 0; m_err = 0; m_idx = 0;
      end
    end else if (v) begin
      if (m_q.size() < N) begin
        m_q.push_back(d);
        m_idx = (m_q.size() < N) ? m_q.size() : N-1;
      end else begin
        if (d == qxor()) begin
          for (int i = 0; i < N; i++) m_wbus[i] = m_q[i];
          m_loaded = 1;
        end else m_err = 1;
        m_busy = 0;
      end
    end
  endtask

  task automatic chk(input string n, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("in_ready", WB'(in_ready), WB'(m_busy));
    chk("busy",     WB'(busy),     WB'(m_busy));
    chk("loaded",   WB'(loaded),   WB'(m_loaded));
    chk("err",      WB'(err),      WB'(m_err));
    chk("idx",      WB'(idx),      WB'(m_idx));
    chk("wbus",     wbus,          m_wbus);
  endtask

  // Drive inputs away from the edge, clock once, advance the model, compare.
  task automatic step(input logic s, input logic v, input logic [31:0] d, input logic r);
    start = s; in_valid = v; in_data = d; reset = r;
    @(posedge clk);
    model(s, v, d, r);
    #1;
    cmp_model();
  endtask

  task automatic good_frame();
    for (int i = 1; i <= N; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h1, 1'b0);
  endtask

  typedef struct {
    logic rst, s, v;
    logic [31:0] d;
    logic e_rdy, e_busy, e_ld, e_err;
    logic [AW-1:0] e_idx;
  } vec_t;
  vec_t tbl[8];

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // rst, start, valid, data | ready, busy, loaded, err, idx
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].rst);
      chk("tbl_ready",  WB'(in_ready), WB'(tbl[i].e_rdy));
      chk("tbl_busy",   WB'(busy),     WB'(tbl[i].e_busy));
      chk("tbl_loaded", WB'(loaded),   WB'(tbl[i].e_ld));
      chk("tbl_err",    WB'(err),      WB'(tbl[i].e_err));
      chk("tbl_idx",    WB'(idx),      WB'(tbl[i].e_idx));
      chk("tbl_wbus",   wbus,          '0);
    end

    // Good frame: 1..17 then checksum 1, commit on the 18th edge after start.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= N; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    chk("good_pre_loaded", WB'(loaded), '0);
    chk("good_pre_idx",    WB'(idx),    WB'(N-1));
    step(1'b0, 1'b1, 32'h1, 1'b0);
    chk("good_loaded", WB'(loaded), WB'(1));
    chk("good_err",    WB'(err),    '0);
    chk("good_busy",   WB'(busy),   '0);
    chk("good_w0",     WB'(wbus[31:0]),         WB'(1));
    chk("good_w16",    WB'(wbus[32*16 +: 32]),  WB'(17));

    // Idle with in_valid high: nothing accepted, wbus unchanged.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("idle_ready", WB'(in_ready), '0);
    chk("idle_w0",    WB'(wbus[31:0]), WB'(1));

    // Bad checksum: wbus keeps the previous frame.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    chk("bad_start_loaded", WB'(loaded), '0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h2, 1'b0);
    chk("bad_err",    WB'(err),    WB'(1));
    chk("bad_loaded", WB'(loaded), '0);
    chk("bad_w0",     WB'(wbus[31:0]),        WB'(1));
    chk("bad_w16",    WB'(wbus[32*16 +: 32]), WB'(17));

    // Backpressure: in_valid 0,1,0,1,... after start; commit lands on edge k+36.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 1; c <= 36; c++) begin
      logic v;
      int   n;
      v = (c % 2 == 0);
      n = c / 2;
      step(1'b0, v, (n <= N) ? 32'(n) : 32'h1, 1'b0);
      if (c == 35) chk("bp_pre_loaded", WB'(loaded), '0);
    end
    chk("bp_loaded", WB'(loaded), WB'(1));
    chk("bp_w16",    WB'(wbus[32*16 +: 32]), WB'(17));

    // Reset mid-load abandons the frame; a fresh frame then commits.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 32'(i + 100), 1'b0);
    step(1'b0, 1'b1, 32'd6, 1'b1);
    chk("rst_wbus", wbus, '0);
    chk("rst_idx",  WB'(idx),  '0);
    chk("rst_busy", WB'(busy), '0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    good_frame();
    chk("rst_refill_loaded", WB'(loaded), WB'(1));
    chk("rst_refill_w0",     WB'(wbus[31:0]), WB'(1));

    // start pulsed at idx=8 is ignored; idx keeps counting.
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    chk("sb_idx8", WB'(idx), WB'(8));
    step(1'b1, 1'b1, 32'd9, 1'b0);
    chk("sb_idx9", WB'(idx), WB'(9));
    for (int i = 10; i <= N; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h1, 1'b0);
    chk("sb_loaded", WB'(loaded), WB'(1));

    // Random traffic; checksum word is sometimes made correct to reach commits.
    for (int c = 0; c < 3000; c++) begin
      logic r, s, v;
      logic [31:0] d;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (m_busy && m_q.size() == N && $urandom_range(0, 1) == 1) d = qxor();
      step(s, v, d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
